// File: rtl/adc_scan_if.sv
// Signal bundle between the ADC scan sequencer, the ADC front end and the
// capture register bank.
interface adc_scan_if #(
  parameter int NUM_CH = 8
);
  logic              start;
  logic              continuous;
  logic              adc_din;
  logic              adc_conv;
  logic [2:0]        adc_sel;
  logic              shift_bit;   // the bank's serial "bit" line; bit is a reserved word
  logic [NUM_CH-1:0] ADC;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, continuous, adc_din,
    output adc_conv, adc_sel, shift_bit, ADC, busy, frame_done
  );

  modport slave (
    output start, continuous, adc_din,
    input  adc_conv, adc_sel, shift_bit, ADC, busy, frame_done
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans NUM_CH ADC channels: convert strobe, conversion wait, then BITS serial
// bits forwarded to the capture bank with a one-hot per-channel shift enable.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int BITS        = 10,
  parameter int CONV_CYCLES = 4
) (
  input logic        clk,
  input logic        reset,
  adc_scan_if.master bus
);
  localparam int CNT_MAX = (BITS > CONV_CYCLES) ? BITS : CONV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]        LAST_CH    = 3'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH0_EN     = NUM_CH'(1);
  localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       ch;
  logic [CNT_W-1:0] cnt;

  // Outputs are loaded on the edge that enters a state, so each output
  // already shows the new state's value during that state's first cycle.
  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ch             <= '0;
      cnt            <= '0;
      bus.adc_conv   <= 1'b0;
      bus.adc_sel    <= '0;
      bus.shift_bit  <= 1'b0;
      bus.ADC        <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.shift_bit  <= bus.adc_din;
      bus.adc_conv   <= 1'b0;
      bus.frame_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= CONV;
            ch           <= '0;
            bus.adc_sel  <= '0;
            bus.adc_conv <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end

        CONV: begin
          if (CONV_CYCLES == 0) begin
            state   <= SHIFT;
            cnt     <= SHIFT_LAST;
            bus.ADC <= CH0_EN << ch;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_LAST;
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            state   <= SHIFT;
            cnt     <= SHIFT_LAST;
            bus.ADC <= CH0_EN << ch;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == '0) begin
            bus.ADC <= '0;
            if (ch == LAST_CH) begin
              state          <= DONE;
              bus.frame_done <= 1'b1;
            end else begin
              state        <= CONV;
              ch           <= ch + 1'b1;
              bus.adc_sel  <= ch + 1'b1;
              bus.adc_conv <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          // The only path by which the channel index wraps back to 0.
          if (bus.continuous) begin
            state        <= CONV;
            ch           <= '0;
            bus.adc_sel  <= '0;
            bus.adc_conv <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench: two sequencer configurations share random stimulus and
// are compared every cycle against a frame-timeline model, plus directed scans.
module tb_adc_scan_sequencer;
  localparam int NA = 8, CA = 4, BA = 10;
  localparam int NB = 2, CB = 0, BB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic adc_din = 1'b0;
  logic check_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  adc_scan_if #(.NUM_CH(NA)) ifa ();
  adc_scan_if #(.NUM_CH(NB)) ifb ();

  assign ifa.start      = start;
  assign ifa.continuous = continuous;
  assign ifa.adc_din    = adc_din;
  assign ifb.start      = start;
  assign ifb.continuous = continuous;
  assign ifb.adc_din    = adc_din;

  adc_scan_sequencer #(.NUM_CH(NA), .BITS(BA), .CONV_CYCLES(CA)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  adc_scan_sequencer #(.NUM_CH(NB), .BITS(BB), .CONV_CYCLES(CB)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a launched frame is just a cycle index k = 1..F, where
  // F = NUM_CH*(1+CONV+BITS)+1 and cycle F is the frame_done cycle.
  function automatic int period(input int d);
    return (d == 0) ? 1 + CA + BA : 1 + CB + BB;
  endfunction

  function automatic int flen(input int d);
    return ((d == 0) ? NA : NB) * period(d) + 1;
  endfunction

  logic m_act [2];
  int   m_k   [2];
  logic din_q;

  always @(posedge clk) begin
    din_q <= reset ? 1'b0 : adc_din;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d] <= 1'b0;
        m_k[d]   <= 0;
      end else if (!m_act[d]) begin
        if (start) begin
          m_act[d] <= 1'b1;
          m_k[d]   <= 1;
        end
      end else if (m_k[d] == flen(d)) begin
        if (continuous) m_k[d] <= 1;
        else            m_act[d] <= 1'b0;
      end else begin
        m_k[d] <= m_k[d] + 1;
      end
    end
  end

  task automatic compare(input int d, input logic conv, input logic [2:0] sel,
                         input logic [7:0] adc, input logic sb, input logic bsy,
                         input logic done);
    int p, ch, r, cc;
    logic e_conv, e_busy, e_done;
    logic [7:0] e_adc;
    string n;
    n = (d == 0) ? "A" : "B";
    p = period(d);
    cc = (d == 0) ? CA : CB;
    e_conv = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_adc = 8'h00;
    if (m_act[d]) begin
      e_busy = 1'b1;
      if (m_k[d] == flen(d)) begin
        e_done = 1'b1;
      end else begin
        ch = (m_k[d] - 1) / p;
        r  = (m_k[d] - 1) % p;
        e_conv = (r == 0);
        if (r > cc) e_adc = 8'(1 << ch);
        check({n, ".adc_sel"}, sel, ch);
      end
    end
    check({n, ".adc_conv"}, conv, e_conv);
    check({n, ".ADC"}, adc, e_adc);
    check({n, ".bit"}, sb, din_q);
    check({n, ".busy"}, bsy, e_busy);
    check({n, ".frame_done"}, done, e_done);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compare(0, ifa.adc_conv, ifa.adc_sel, 8'(ifa.ADC), ifa.shift_bit, ifa.busy, ifa.frame_done);
      compare(1, ifb.adc_conv, ifb.adc_sel, 8'(ifb.ADC), ifb.shift_bit, ifb.busy, ifb.frame_done);
    end
  end

  // Directed-frame bookkeeping (configuration A unless named _b).
  logic [9:0] pat [8];
  logic [9:0] cap [8];
  int adc_len [8];
  int done_cyc, done_cnt, conv_cnt, sel_bad, busy_after;
  int first_b0, first_b1, conv_b0, conv_b1, done_b;

  // adc_din value needed during cycle c-1 so configuration A shifts pat[] in cycle c.
  function automatic logic din_for(input int c);
    int r, ch;
    r  = (c - 1) % 15;
    ch = (c - 1) / 15;
    if (c >= 1 && ch < 8 && r >= 5) return pat[ch][9 - (r - 5)];
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      adc_din = 1'($urandom);
    end
  endtask

  task automatic run_frame(input logic hold);
    done_cyc = -1; done_cnt = 0; conv_cnt = 0; sel_bad = 0; busy_after = 0;
    first_b0 = -1; first_b1 = -1; conv_b0 = -1; conv_b1 = -1; done_b = -1;
    for (int k = 0; k < 8; k++) begin
      cap[k] = '0;
      adc_len[k] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    adc_din = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 126; c++) begin
      @(negedge clk);
      if (ifa.frame_done) begin done_cnt++; done_cyc = c; end
      if (ifa.adc_conv) begin
        if (ifa.adc_sel != 3'(conv_cnt)) sel_bad++;
        conv_cnt++;
      end
      for (int k = 0; k < 8; k++) begin
        if (ifa.ADC[k]) begin
          cap[k] = {cap[k][8:0], ifa.shift_bit};
          adc_len[k]++;
        end
      end
      if (c > 121 && ifa.busy) busy_after++;
      if (ifb.ADC[0] && first_b0 < 0) first_b0 = c;
      if (ifb.ADC[1] && first_b1 < 0) first_b1 = c;
      if (ifb.adc_conv) begin
        if (conv_b0 < 0) conv_b0 = c;
        else if (conv_b1 < 0) conv_b1 = c;
      end
      if (ifb.frame_done && done_b < 0) done_b = c;
      if (!hold || c >= 121) start = 1'b0;
      adc_din = din_for(c + 1);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".done_cycle"}, done_cyc, 121);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".conv_count"}, conv_cnt, 8);
    check({tag, ".sel_order_errs"}, sel_bad, 0);
    check({tag, ".busy_after_done"}, busy_after, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s.ch%0d_bits", tag, k), cap[k], pat[k]);
      check($sformatf("%s.ch%0d_en_len", tag, k), adc_len[k], 10);
    end
  endtask

  int dcyc [3];
  int nd, busy_low, busy_tail, post_rst_done;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.adc_conv", ifa.adc_conv, 0);
    check("rst.adc_sel", ifa.adc_sel, 0);
    check("rst.bit", ifa.shift_bit, 0);
    check("rst.ADC", ifa.ADC, 0);
    check("rst.busy", ifa.busy, 0);
    check("rst.frame_done", ifa.frame_done, 0);
    check_en = 1'b1;
    reset = 1'b0;
    idle(5);

    // One-shot frame, channel k shifts 10'h3A0+k; small config timing too.
    for (int k = 0; k < 8; k++) pat[k] = 10'h3A0 + 10'(k);
    run_frame(1'b0);
    check_frame("oneshot");
    check("B.conv0_cycle", conv_b0, 1);
    check("B.ADC0_first", first_b0, 2);
    check("B.conv1_cycle", conv_b1, 6);
    check("B.ADC1_first", first_b1, 7);
    check("B.done_cycle", done_b, 11);
    idle(20);

    // Boundary bit patterns.
    for (int k = 0; k < 8; k++) pat[k] = 10'h2AA;
    pat[0] = 10'h3FF;
    pat[7] = 10'h000;
    run_frame(1'b0);
    check_frame("boundary");
    idle(20);

    // start held through the whole frame: exactly one frame, then IDLE.
    run_frame(1'b1);
    check_frame("held_start");
    idle(20);
    run_frame(1'b0);
    check_frame("second_frame");
    idle(20);

    // Continuous scanning, dropped during the third frame.
    continuous = 1'b1;
    nd = 0; busy_low = 0; busy_tail = 0;
    for (int i = 0; i < 3; i++) dcyc[i] = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 370; c++) begin
      @(negedge clk);
      if (ifa.frame_done) begin
        if (nd < 3) dcyc[nd] = c;
        nd++;
      end
      if (c <= 363 && !ifa.busy) busy_low++;
      if (c > 363 && ifa.busy) busy_tail++;
      start = 1'b0;
      if (c == 300) continuous = 1'b0;
      adc_din = 1'($urandom);
    end
    check("cont.done_count", nd, 3);
    check("cont.done1", dcyc[0], 121);
    check("cont.done2", dcyc[1], 242);
    check("cont.done3", dcyc[2], 363);
    check("cont.busy_gaps", busy_low, 0);
    check("cont.busy_tail", busy_tail, 0);
    idle(20);

    // Reset during channel 3 SHIFT, bit 5 (cycle 56).
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 56) begin
        check("midrst.ADC_before", ifa.ADC, 8'h08);
        check("midrst.sel_before", ifa.adc_sel, 3);
        reset = 1'b1;
      end else begin
        adc_din = 1'($urandom);
      end
    end
    @(negedge clk);
    check("midrst.adc_conv", ifa.adc_conv, 0);
    check("midrst.adc_sel", ifa.adc_sel, 0);
    check("midrst.bit", ifa.shift_bit, 0);
    check("midrst.ADC", ifa.ADC, 0);
    check("midrst.busy", ifa.busy, 0);
    check("midrst.frame_done", ifa.frame_done, 0);
    reset = 1'b0;
    post_rst_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (ifa.frame_done) post_rst_done++;
    end
    check("midrst.no_done", post_rst_done, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart.adc_conv", ifa.adc_conv, 1);
    check("restart.adc_sel", ifa.adc_sel, 0);
    check("restart.busy", ifa.busy, 1);
    repeat (5) @(negedge clk);
    check("restart.ADC_c6", ifa.ADC, 8'h01);
    idle(130);

    // Random stimulus, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      adc_din = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) continuous = ~continuous;
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    continuous = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Upstream controller for the 8-channel ADC capture register bank.
- Scans NUM_CH ADC channels in order. Per channel: issues a convert strobe, waits the conversion time, then streams BITS serial bits.
- Drives the bank's shared serial data line (bit) and its one-hot per-channel shift enables (ADC).
- Pulses frame_done once all channel registers hold a fresh sample set. Supports one-shot and continuous scanning.

Parameters:
- NUM_CH, 8, number of channels scanned per frame; width of ADC enable bus.
- BITS, 10, serial bits shifted per channel.
- CONV_CYCLES, 4, wait cycles between convert strobe and first shifted bit (0 allowed).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- continuous  input  1  restart a new frame automatically after frame_done while high
- adc_din  input  1  serial data from the ADC front end, MSB first
- adc_conv  output  1  convert strobe to the ADC, one cycle per channel
- adc_sel  output  3  channel select to the ADC mux, equal to current channel index
- bit  output  1  serial data to the capture bank, registered copy of adc_din
- ADC  output  NUM_CH  one-hot shift enable to the capture bank; bit k enables channel k
- busy  output  1  high while a frame is in progress
- frame_done  output  1  one-cycle pulse when the last channel's last bit has been delivered

Behaviour:
- All outputs are registered.
- Reset values: adc_conv=0, adc_sel=0, bit=0, ADC=0, busy=0, frame_done=0. FSM goes to IDLE; channel and bit counters cleared.
- reset has priority over every other input in every state. Reset mid-frame aborts immediately; no frame_done is produced. The next frame restarts at channel 0.
- States:
  - IDLE: start=1 moves to CONV with ch=0 and sets busy=1 on the same edge. start=0 stays in IDLE.
  - CONV: adc_conv=1 and adc_sel=ch for exactly one cycle. Next state is WAIT, or SHIFT directly if CONV_CYCLES=0.
  - WAIT: exactly CONV_CYCLES cycles with adc_conv=0 and ADC=0, then SHIFT.
  - SHIFT: exactly BITS consecutive cycles with ADC=(1<<ch) and all other bits 0.
    - In each SHIFT cycle, bit equals the adc_din value sampled on the preceding clock edge.
    - The first bit delivered is the MSB.
    - After BITS cycles: if ch<NUM_CH-1, increment ch and go to CONV; otherwise go to DONE.
  - DONE: frame_done=1 for one cycle, ADC=0. If continuous=1, go to CONV with ch=0 and keep busy=1. Otherwise go to IDLE and set busy=0 on the following edge.
- adc_sel holds the current ch from CONV through the end of that channel's SHIFT.
- Per-channel period is 1+CONV_CYCLES+BITS cycles. With defaults, that is 15 cycles per channel; a frame is 8×15=120 cycles plus 1 DONE cycle.
- Timing from start, with start sampled at edge 0:
  - adc_conv is high in cycle 1.
  - The first ADC enable is high in cycle 1+CONV_CYCLES+1.
  - frame_done is high in cycle NUM_CH*(1+CONV_CYCLES+BITS)+1; defaults give cycle 121.
- start asserted while busy=1, including during DONE, is ignored and not queued.
- continuous is sampled only in DONE. Deasserting it mid-frame lets the current frame complete, then returns to IDLE.
- ADC is never multi-hot. ADC=0 in IDLE, CONV, WAIT and DONE.
- Channel index wraps NUM_CH-1 → 0 only through DONE.

Test Plan:
- One-shot frame, defaults: drive adc_din so channel k shifts value 10'h3A0+k MSB first, pulse start → adc_conv pulses 8 times 15 cycles apart. Each ADC[k] is high for 10 consecutive cycles. bit sequence per channel equals 10'h3A0+k MSB first. frame_done is high at cycle 121 only; busy falls the cycle after.
- Boundary patterns: channel 0 = 10'h3FF, channel 7 = 10'h000, others 10'h2AA → bit matches exactly. ADC is one-hot or zero every cycle. adc_sel = 0..7 in order.
- start held high for the whole frame → exactly one frame runs, and the frame returns to IDLE. A new start after busy=0 launches a second, identical frame.
- continuous=1 for two frames, then deasserted mid third frame → frame_done at cycles 121, 242 and 363. busy stays high throughout, then falls after the third frame_done.
- Reset asserted during channel 3 SHIFT, bit 5 → next cycle all outputs are 0 and the FSM is in IDLE, with no frame_done. A subsequent start restarts at channel 0 with adc_sel=0.
- CONV_CYCLES=0, BITS=4, NUM_CH=2 → ADC[0] is high in cycles 2–5, adc_conv is high in cycles 1 and 6, ADC[1] is high in cycles 7–10, and frame_done is high in cycle 11.
